// File: rtl/fmul_pkg.sv
// Shared constants and types for the FloatMul mantissa datapaths.
// Defaults target half precision (11-bit mantissa with hidden bit).
package fmul_pkg;
  localparam int MW_DEF = 11;
  localparam int QW_DEF = MW_DEF + 2;
  localparam int CNT_W  = $clog2(QW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: compare, conditionally subtract, shift left.
// Kept combinational and standalone so an unrolled divider can chain copies.
module div_sub_stage #(
  parameter int MW = 11
) (
  input  logic [MW+1:0] i_rem,
  input  logic [MW:0]   i_div,
  output logic          o_ge,
  output logic [MW+1:0] o_next_rem
);
  logic [MW+1:0] w_div_ext;
  logic [MW+1:0] w_diff;

  assign w_div_ext  = {1'b0, i_div};
  assign o_ge       = (i_rem >= w_div_ext);
  assign w_diff     = i_rem - w_div_ext;
  // rem < 2*div keeps bit MW+1 clear before the shift, so nothing is lost
  assign o_next_rem = (o_ge ? w_diff : i_rem) << 1;
endmodule

// File: rtl/mant_div_seq.sv
// Iterative restoring mantissa divider, one quotient bit per clock,
// producing q = floor(a*2^(QW-1)/b) plus sticky for the shared rounder.
module mant_div_seq
  import fmul_pkg::*;
#(
  parameter int MW = MW_DEF,
  parameter int QW = MW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] a_mant,
  input  logic [MW-1:0] b_mant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] q,
  output logic          sticky,
  output logic          norm,
  output logic          dz
);
  localparam int CW = $clog2(QW);

  div_state_e    r_state;
  logic [MW+1:0] r_rem;
  logic [MW:0]   r_div;
  logic [CW-1:0] r_cnt;
  logic [QW-1:0] r_q;
  logic          r_sticky;
  logic          r_norm;
  logic          r_dz;
  logic          r_in_ready;
  logic          r_out_valid;

  logic          w_ge;
  logic [MW+1:0] w_next_rem;

  div_sub_stage #(.MW(MW)) u_step (
    .i_rem      (r_rem),
    .i_div      (r_div),
    .o_ge       (w_ge),
    .o_next_rem (w_next_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_q         <= '0;
      r_sticky    <= 1'b0;
      r_norm      <= 1'b0;
      r_dz        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (b_mant == '0) begin
              // Saturated quotient; norm tracks q's top bit
              r_q         <= '1;
              r_sticky    <= 1'b1;
              r_norm      <= 1'b1;
              r_dz        <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_rem    <= {2'b00, a_mant};
              r_div    <= {1'b0, b_mant};
              r_q      <= '0;
              r_sticky <= 1'b0;
              r_norm   <= 1'b0;
              r_dz     <= 1'b0;
              r_cnt    <= CW'(QW - 1);
              r_state  <= CALC;
            end
          end
        end
        CALC: begin
          r_q[r_cnt] <= w_ge;
          r_rem      <= w_next_rem;
          if (r_cnt == CW'(QW - 1)) r_norm <= w_ge;
          if (r_cnt == '0) begin
            r_sticky    <= |w_next_rem;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign sticky    = r_sticky;
  assign norm      = r_norm;
  assign dz        = r_dz;
endmodule

// File: tb/tb_mant_div_seq.sv
// Self-checking bench for mant_div_seq: directed table, corner sequences,
// and a randomized back-to-back stream against an arithmetic reference.
module tb_mant_div_seq;
  localparam int MW = 11;
  localparam int QW = MW + 2;
  localparam int NRAND = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] a_mant;
  logic [MW-1:0] b_mant;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] q;
  logic          sticky;
  logic          norm;
  logic          dz;

  mant_div_seq #(.MW(MW), .QW(QW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .sticky    (sticky),
    .norm      (norm),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer division of the scaled dividend
  function automatic void ref_div(input longint a, input longint b,
                                  output longint rq, output longint rs,
                                  output longint rn, output longint rd);
    longint num;
    num = a * (longint'(1) << (QW - 1));
    if (b == 0) begin
      rq = (longint'(1) << QW) - 1; rs = 1; rn = 1; rd = 1;
    end else begin
      rq = num / b;
      rs = ((num % b) != 0) ? 1 : 0;
      rn = (rq >> (QW - 1)) & 1;
      rd = 0;
    end
  endfunction

  // Stream monitor
  longint cyc = 0;
  bit     mon_en = 1'b0;
  longint acc_a[$], acc_b[$], acc_cyc[$];
  longint res_q[$], res_s[$], res_n[$], res_d[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && !rst) begin
      if (in_valid && in_ready) begin
        acc_a.push_back(longint'(a_mant));
        acc_b.push_back(longint'(b_mant));
        acc_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        res_q.push_back(longint'(q));
        res_s.push_back(longint'(sticky));
        res_n.push_back(longint'(norm));
        res_d.push_back(longint'(dz));
      end
    end
  end

  task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit noise,
                        output logic [QW-1:0] rq, output logic rs, output logic rn,
                        output logic rd, output int lat);
    in_valid = 1'b1; a_mant = a; b_mant = b;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 64) begin
      if (noise) begin
        a_mant = MW'($urandom); b_mant = MW'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    rq = q; rs = sticky; rn = norm; rd = dz;
  endtask

  task automatic release_result(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_in_ready_after"}, longint'(in_ready), 1);
    chk({nm, "_out_valid_after"}, longint'(out_valid), 0);
  endtask

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [QW-1:0] eq;
    logic          es;
    logic          en;
    logic          ed;
    int            elat;
  } vec_t;

  initial begin
    vec_t tbl[7];
    logic [QW-1:0] rq;
    logic rs, rn, rd;
    int lat;
    longint eq, es, en, ed;
    bit seen;
    logic [QW-1:0] hq;

    tbl[0] = '{11'h400, 11'h400, 13'h1000, 1'b0, 1'b1, 1'b0, 14};
    tbl[1] = '{11'h600, 11'h400, 13'h1800, 1'b0, 1'b1, 1'b0, 14};
    tbl[2] = '{11'h400, 11'h600, 13'h0AAA, 1'b1, 1'b0, 1'b0, 14};
    tbl[3] = '{11'h7FF, 11'h7FF, 13'h1000, 1'b0, 1'b1, 1'b0, 14};
    tbl[4] = '{11'h400, 11'h7FF, 13'h0801, 1'b1, 1'b0, 1'b0, 14};
    tbl[5] = '{11'h7FF, 11'h401, 13'h1FF4, 1'b1, 1'b1, 1'b0, 14};
    tbl[6] = '{11'h5A5, 11'h000, 13'h1FFF, 1'b1, 1'b1, 1'b1, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_mant = '0; b_mant = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_q", longint'(q), 0);
    chk("rst_flags", longint'({sticky, norm, dz}), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, 1'b0, rq, rs, rn, rd, lat);
      chk($sformatf("tbl%0d_q", i), longint'(rq), longint'(tbl[i].eq));
      chk($sformatf("tbl%0d_sticky", i), longint'(rs), longint'(tbl[i].es));
      chk($sformatf("tbl%0d_norm", i), longint'(rn), longint'(tbl[i].en));
      chk($sformatf("tbl%0d_dz", i), longint'(rd), longint'(tbl[i].ed));
      chk($sformatf("tbl%0d_latency", i), longint'(lat), longint'(tbl[i].elat));
      release_result($sformatf("tbl%0d", i));
    end

    // Back-pressure: result held while out_ready stays low
    run_op(11'h7FF, 11'h400, 1'b0, rq, rs, rn, rd, lat);
    chk("hold_q", longint'(rq), 'h1FFC);
    chk("hold_sticky", longint'(rs), 0);
    hq = rq;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_q", k), longint'(q), longint'(hq));
      chk($sformatf("hold%0d_valid", k), longint'(out_valid), 1);
      chk($sformatf("hold%0d_in_ready", k), longint'(in_ready), 0);
    end
    release_result("hold");

    // in_valid kept high with changing data during CALC must not disturb the result
    run_op(11'h600, 11'h500, 1'b1, rq, rs, rn, rd, lat);
    ref_div('h600, 'h500, eq, es, en, ed);
    chk("noise_q", longint'(rq), eq);
    chk("noise_sticky", longint'(rs), es);
    release_result("noise");

    // Asynchronous reset in the middle of an iteration
    in_valid = 1'b1; a_mant = 11'h400; b_mant = 11'h600;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_q", longint'(q), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", longint'(seen), 0);
    run_op(11'h600, 11'h400, 1'b0, rq, rs, rn, rd, lat);
    chk("postrst_q", longint'(rq), 'h1800);
    chk("postrst_latency", longint'(lat), 14);
    release_result("postrst");

    // Randomized back-to-back stream with out_ready held high
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < NRAND; i++) begin
      int budget;
      in_valid = 1'b1;
      a_mant = MW'($urandom_range(2 ** MW - 1, 2 ** (MW - 1)));
      b_mant = MW'($urandom_range(2 ** MW - 1, 2 ** (MW - 1)));
      budget = 0;
      while (!in_ready && budget < 64) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!in_ready) chk("stream_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 64 && res_q.size() < NRAND; k++) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    out_ready = 1'b0;

    chk("stream_accepts", longint'(acc_a.size()), NRAND);
    chk("stream_results", longint'(res_q.size()), NRAND);
    for (int i = 0; i < NRAND && i < res_q.size() && i < acc_a.size(); i++) begin
      ref_div(acc_a[i], acc_b[i], eq, es, en, ed);
      chk($sformatf("rnd%0d_q a=%0h b=%0h", i, acc_a[i], acc_b[i]), res_q[i], eq);
      chk($sformatf("rnd%0d_sticky", i), res_s[i], es);
      chk($sformatf("rnd%0d_norm", i), res_n[i], en);
      chk($sformatf("rnd%0d_dz", i), res_d[i], ed);
      if (i > 0) chk($sformatf("rnd%0d_interval", i), acc_cyc[i] - acc_cyc[i-1], QW + 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
